// File: rtl/scan_pkg.sv
// scan_pkg: shared types and helpers for the scan address generator.
//   scan_state_t : FSM state encoding (IDLE, RUN)
//   ADDR_W       : width of the scan address (drives a 3-to-8 decoder)
//   next_addr()  : address step with wrap detection, up or down
package scan_pkg;

  localparam int ADDR_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wrap;
  } scan_step_t;

  // Next scan address. Up-counting wraps LAST->0, down-counting wraps 0->LAST;
  // the wrap flag marks exactly that wrapping step.
  function automatic scan_step_t next_addr(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] last,
    input logic              down
  );
    scan_step_t s;
    if (down) begin
      if (addr == ADDR_W'(0)) begin
        s.addr = last;
        s.wrap = 1'b1;
      end else begin
        s.addr = addr - ADDR_W'(1);
        s.wrap = 1'b0;
      end
    end else begin
      if (addr == last) begin
        s.addr = ADDR_W'(0);
        s.wrap = 1'b1;
      end else begin
        s.addr = addr + ADDR_W'(1);
        s.wrap = 1'b0;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/scan_dwell_cnt.sv
// scan_dwell_cnt: counts the cycles an address is held.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   clr  - synchronous clear of the count
//   en   - count enable (high while scanning)
//   done - high in the cycle the count equals DWELL-1 (the advance cycle)
module scan_dwell_cnt #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [7:0] TERM = 8'(DWELL - 1);

  logic [7:0] count_r;

  // Dwell count: wraps to zero on the terminal value so the address advances every DWELL cycles.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_r <= 8'd0;
    end else if (en) begin
      if (count_r == TERM) begin
        count_r <= 8'd0;
      end else begin
        count_r <= count_r + 8'd1;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign done = en && (count_r == TERM);

endmodule

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: scan address generator for a 3-to-8 decoder.
// Holds each address for DWELL cycles, scanning 0..LAST and wrapping.
// Optional macro SCAN_DOWN_EN adds a 'dir' input for down-counting.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   start      - begin scanning when idle (stop has priority)
//   stop       - abort scanning, return to idle
//   dir        - (SCAN_DOWN_EN only) 0 = count up, 1 = count down
//   A2, A1, A0 - registered scan address, MSB..LSB
//   busy       - high while scanning
//   wrap       - one-cycle pulse coincident with the wrapped address
module scan_addr_gen
  import scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int LAST  = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
`ifdef SCAN_DOWN_EN
  input  logic dir,
`endif
  output logic A2,
  output logic A1,
  output logic A0,
  output logic busy,
  output logic wrap
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST);

  scan_state_t       state_r;
  logic [ADDR_W-1:0] addr_r;
  logic              busy_r;
  logic              wrap_r;
  logic              down_s;
  logic              dwell_clr_s;
  logic              dwell_en_s;
  logic              dwell_done_s;
  scan_step_t        step_s;

`ifdef SCAN_DOWN_EN
  assign down_s = dir;
`else
  assign down_s = 1'b0;
`endif

  // The count is held at zero while idle and cleared on stop, so every RUN entry starts fresh.
  assign dwell_clr_s = (state_r == IDLE) || stop;
  assign dwell_en_s  = (state_r == RUN);
  assign step_s      = next_addr(addr_r, LAST_A, down_s);

  scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (dwell_clr_s),
    .en   (dwell_en_s),
    .done (dwell_done_s)
  );

  // Scan FSM with registered address, busy and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= ADDR_W'(0);
      busy_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !stop) begin
            state_r <= RUN;
            addr_r  <= down_s ? LAST_A : ADDR_W'(0);
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            addr_r  <= ADDR_W'(0);
            busy_r  <= 1'b0;
          end
          wrap_r <= 1'b0;
        end
        RUN: begin
          if (stop) begin
            state_r <= IDLE;
            addr_r  <= ADDR_W'(0);
            busy_r  <= 1'b0;
            wrap_r  <= 1'b0;
          end else if (dwell_done_s) begin
            // dir only matters here, at the advance edge.
            addr_r  <= step_s.addr;
            wrap_r  <= step_s.wrap;
          end else begin
            wrap_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          addr_r  <= ADDR_W'(0);
          busy_r  <= 1'b0;
          wrap_r  <= 1'b0;
        end
      endcase
    end
  end

  assign {A2, A1, A0} = addr_r;
  assign busy         = busy_r;
  assign wrap         = wrap_r;

endmodule
